rf_operand_fetch: RTL

//   Initiator side of the register_file read/write interface. Accepts one instruction at a time (rs0, rs1, rd).

---
 rtl/rf_operand_fetch.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rf_operand_fetch.sv
// Operand fetch stage: tracks outstanding register writes, stalls on RAW hazards,
// reads the register file with same-cycle writeback bypass, and forwards writeback.
module rf_operand_fetch #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [ADDR_W-1:0]   issue_rs0,
    input  logic [ADDR_W-1:0]   issue_rs1,
    input  logic [1:0]          issue_use,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                issue_rd_en,
    output logic                op_valid,
    input  logic                op_ready,
    output logic [DATA_W-1:0]   op_data_0,
    output logic [DATA_W-1:0]   op_data_1,
    output logic [ADDR_W-1:0]   op_rd,
    output logic                op_rd_en,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    output logic [1:0]          rf_read_en,
    output logic [ADDR_W-1:0]   rf_raddr_0,
    output logic [ADDR_W-1:0]   rf_raddr_1,
    input  logic [DATA_W-1:0]   rf_rdata_0,
    input  logic [DATA_W-1:0]   rf_rdata_1,
    output logic                rf_write_en,
    output logic [ADDR_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic [NUM_REGS-1:0] busy,
    output logic [1:0]          dbg_state
);

    // Handshakes: a transfer happens on a posedge where valid && ready; the
    // sender holds its payload stable while valid is high and ready is low.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_rs0;
    logic [ADDR_W-1:0]   r_rs1;
    logic [1:0]          r_use;
    logic [ADDR_W-1:0]   r_rd;
    logic                r_rd_en;
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [DATA_W-1:0]   r_op_data_0;
    logic [DATA_W-1:0]   r_op_data_1;
    logic [ADDR_W-1:0]   r_op_rd;
    logic                r_op_rd_en;

    logic                w_byp0;
    logic                w_byp1;
    logic                w_hazard;
    logic                w_resolve;
    logic                w_accept;
    logic [DATA_W-1:0]   w_op0;
    logic [DATA_W-1:0]   w_op1;

    // A writeback landing this cycle satisfies a busy source via the bypass.
    assign w_byp0    = wb_valid && (wb_addr == r_rs0);
    assign w_byp1    = wb_valid && (wb_addr == r_rs1);
    assign w_hazard  = (r_use[0] && r_busy[r_rs0] && !w_byp0) ||
                       (r_use[1] && r_busy[r_rs1] && !w_byp1);
    assign w_resolve = (r_state == ST_FETCH) && !w_hazard;
    assign w_accept  = issue_valid && issue_ready;
    assign w_op0     = r_use[0] ? (w_byp0 ? wb_data : rf_rdata_0) : '0;
    assign w_op1     = r_use[1] ? (w_byp1 ? wb_data : rf_rdata_1) : '0;

    always_comb begin
        w_state_nxt = r_state;
        issue_ready = 1'b0;
        rf_read_en  = 2'b00;
        rf_raddr_0  = '0;
        rf_raddr_1  = '0;
        case (r_state)
            ST_IDLE: begin
                issue_ready = 1'b1;
                if (issue_valid) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (w_resolve) begin
                    rf_read_en  = r_use;
                    rf_raddr_0  = r_rs0;
                    rf_raddr_1  = r_rs1;
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                issue_ready = op_ready;
                if (op_ready) w_state_nxt = issue_valid ? ST_FETCH : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Clear before set so a resolving writer to wb_addr leaves the bit set.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_valid) w_busy_nxt[wb_addr] = 1'b0;
        if (w_resolve && r_rd_en) w_busy_nxt[r_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_rs0       <= '0;
            r_rs1       <= '0;
            r_use       <= 2'b00;
            r_rd        <= '0;
            r_rd_en     <= 1'b0;
            r_busy      <= '0;
            r_op_data_0 <= '0;
            r_op_data_1 <= '0;
            r_op_rd     <= '0;
            r_op_rd_en  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            if (w_accept) begin
                r_rs0   <= issue_rs0;
                r_rs1   <= issue_rs1;
                r_use   <= issue_use;
                r_rd    <= issue_rd;
                r_rd_en <= issue_rd_en;
            end
            if (w_resolve) begin
                r_op_data_0 <= w_op0;
                r_op_data_1 <= w_op1;
                r_op_rd     <= r_rd;
                r_op_rd_en  <= r_rd_en;
            end
        end
    end

    assign op_valid    = (r_state == ST_OUT);
    assign op_data_0   = r_op_data_0;
    assign op_data_1   = r_op_data_1;
    assign op_rd       = r_op_rd;
    assign op_rd_en    = r_op_rd_en;
    assign rf_write_en = wb_valid;
    assign rf_waddr    = wb_addr;
    assign rf_wdata    = wb_data;
    assign busy        = r_busy;
    assign dbg_state   = r_state;

endmodule
